vend_sequencer: RTL and testbench

Transaction controller for the vending datapath. Accumulates coin credit, validates selections against price and stock, sequences the dispense motor with a timeout, and pays change through a 10c coin hopper. It sits between the coin/keypad front-end and the motor/hopper actuators, and owns the per-slot stock counters.

---
 rtl/vend_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_vend_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_sequencer.sv
// Vending transaction controller: coin credit, selection checks, motor
// sequencing with timeout, change payout through a 10c hopper, and the
// per-slot stock counters.
module vend_sequencer #(
    parameter int P0            = 10,
    parameter int P1            = 20,
    parameter int P2            = 30,
    parameter int P3            = 40,
    parameter int INIT_STOCK    = 4,
    parameter int MOTOR_TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic [1:0] coin_value,
    input  logic       select_valid,
    input  logic [1:0] select,
    input  logic       cancel,
    input  logic       restock_we,
    input  logic [1:0] restock_slot,
    input  logic [3:0] restock_count,
    input  logic       motor_done,
    input  logic       hopper_ack,
    output logic       motor_req,
    output logic [1:0] motor_slot,
    output logic       hopper_req,
    output logic [7:0] credit,
    output logic [2:0] state_o,
    output logic       coin_reject,
    output logic       err_stock,
    output logic       err_funds,
    output logic [3:0] stock_empty
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CREDIT = 3'd1,
        VEND   = 3'd2,
        CHANGE = 3'd3,
        FAULT  = 3'd4
    } state_t;

    localparam int TW = $clog2(MOTOR_TIMEOUT + 1);

    state_t          state;
    logic [TW-1:0]   timer;
    logic [3:0]      stock [4];

    logic [8:0]      coin_amount;
    logic [8:0]      coin_sum;
    logic            open_state;
    logic            coin_ok;
    logic [7:0]      coin_add;
    logic [7:0]      sel_price;
    logic            sel_empty;
    logic            sel_funds_low;

    function automatic logic [7:0] price_of(input logic [1:0] s);
        case (s)
            2'd0:    price_of = 8'(P0);
            2'd1:    price_of = 8'(P1);
            2'd2:    price_of = 8'(P2);
            default: price_of = 8'(P3);
        endcase
    endfunction

    assign state_o = state;

    // Decode the coin, decide whether it fits in the 8-bit credit, and
    // pre-evaluate the selection against the credit held before this edge.
    always_comb begin
        coin_amount = 9'd10;
        case (coin_value)
            2'b00:   coin_amount = 9'd10;
            2'b01:   coin_amount = 9'd20;
            2'b10:   coin_amount = 9'd50;
            default: coin_amount = 9'd100;
        endcase
        coin_sum      = {1'b0, credit} + coin_amount;
        open_state    = (state == IDLE) || (state == CREDIT);
        coin_ok       = coin_valid && open_state && (coin_sum <= 9'd255);
        coin_add      = coin_ok ? coin_amount[7:0] : 8'd0;
        sel_price     = price_of(select);
        sel_empty     = (stock[select] == 4'd0);
        sel_funds_low = (credit < sel_price);
    end

    // Transaction state machine with all outputs and stock counters registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            credit      <= 8'd0;
            timer       <= '0;
            motor_req   <= 1'b0;
            motor_slot  <= 2'd0;
            hopper_req  <= 1'b0;
            coin_reject <= 1'b0;
            err_stock   <= 1'b0;
            err_funds   <= 1'b0;
            stock_empty <= {4{INIT_STOCK == 0}};
            for (int i = 0; i < 4; i++) begin
                stock[i] <= 4'(INIT_STOCK);
            end
        end else begin
            coin_reject <= coin_valid && !coin_ok;
            err_stock   <= 1'b0;
            err_funds   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                stock_empty[i] <= (stock[i] == 4'd0);
            end

            case (state)
                IDLE, CREDIT: begin
                    if (restock_we) begin
                        stock[restock_slot] <= restock_count;
                    end
                    if (select_valid && sel_empty) begin
                        err_stock <= 1'b1;
                        credit    <= credit + coin_add;
                        if (coin_ok) state <= CREDIT;
                    end else if (select_valid && sel_funds_low) begin
                        err_funds <= 1'b1;
                        credit    <= credit + coin_add;
                        if (coin_ok) state <= CREDIT;
                    end else if (select_valid) begin
                        credit     <= credit - sel_price + coin_add;
                        motor_req  <= 1'b1;
                        motor_slot <= select;
                        timer      <= '0;
                        state      <= VEND;
                    end else if (cancel && state == CREDIT) begin
                        credit     <= credit + coin_add;
                        hopper_req <= ((credit + coin_add) != 8'd0);
                        state      <= CHANGE;
                    end else if (coin_ok) begin
                        credit <= credit + coin_add;
                        state  <= CREDIT;
                    end
                end

                VEND: begin
                    if (motor_done) begin
                        motor_req <= 1'b0;
                        if (stock[motor_slot] != 4'd0) begin
                            stock[motor_slot] <= stock[motor_slot] - 4'd1;
                        end
                        if (credit != 8'd0) begin
                            hopper_req <= 1'b1;
                            state      <= CHANGE;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (timer == TW'(MOTOR_TIMEOUT - 1)) begin
                        motor_req <= 1'b0;
                        credit    <= credit + price_of(motor_slot);
                        state     <= FAULT;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                FAULT: begin
                    hopper_req <= (credit != 8'd0);
                    state      <= CHANGE;
                end

                CHANGE: begin
                    if (credit == 8'd0) begin
                        hopper_req <= 1'b0;
                        state      <= IDLE;
                    end else if (hopper_req && hopper_ack) begin
                        credit <= credit - 8'd10;
                        if (credit == 8'd10) begin
                            hopper_req <= 1'b0;
                            state      <= IDLE;
                        end
                    end else begin
                        hopper_req <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed self-checking bench for vend_sequencer.
module tb_vend_sequencer;

    localparam int MT = 1000;

    logic       clk = 1'b0;
    logic       reset;
    logic       coin_valid, select_valid, cancel, restock_we, motor_done, hopper_ack;
    logic [1:0] coin_value, select, restock_slot;
    logic [3:0] restock_count;
    logic       motor_req, hopper_req, coin_reject, err_stock, err_funds;
    logic [1:0] motor_slot;
    logic [7:0] credit;
    logic [2:0] state_o;
    logic [3:0] stock_empty;

    int errors = 0;
    int checks = 0;
    int overlap = 0;
    bit hopper_seen = 0;

    vend_sequencer #(.MOTOR_TIMEOUT(MT)) dut (
        .clk(clk), .reset(reset),
        .coin_valid(coin_valid), .coin_value(coin_value),
        .select_valid(select_valid), .select(select), .cancel(cancel),
        .restock_we(restock_we), .restock_slot(restock_slot), .restock_count(restock_count),
        .motor_done(motor_done), .hopper_ack(hopper_ack),
        .motor_req(motor_req), .motor_slot(motor_slot), .hopper_req(hopper_req),
        .credit(credit), .state_o(state_o), .coin_reject(coin_reject),
        .err_stock(err_stock), .err_funds(err_funds), .stock_empty(stock_empty)
    );

    always #5 clk = ~clk;

    // Watch the actuator requests between edges.
    always @(negedge clk) begin
        if (hopper_req === 1'b1) hopper_seen = 1;
        if (motor_req === 1'b1 && hopper_req === 1'b1) overlap++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic insert_coin(input logic [1:0] v);
        coin_valid = 1; coin_value = v;
        tick();
        coin_valid = 0;
    endtask

    task automatic press(input logic [1:0] s);
        select_valid = 1; select = s;
        tick();
        select_valid = 0;
    endtask

    task automatic pulse_done();
        motor_done = 1;
        tick();
        motor_done = 0;
    endtask

    task automatic pulse_cancel();
        cancel = 1;
        tick();
        cancel = 0;
    endtask

    // Hold hopper_ack high until the payout ends; return the coins paid.
    task automatic drain(output int paid);
        paid = 0;
        hopper_ack = 1;
        for (int i = 0; i < 40; i++) begin
            if (hopper_req === 1'b1) paid++;
            tick();
            if (state_o == 3'd0) break;
        end
        hopper_ack = 0;
    endtask

    // Vend slot 1 with exact 20c until err_stock appears; return vend count.
    task automatic count_slot1(output int vends);
        int paid;
        vends = 0;
        for (int i = 0; i < 16; i++) begin
            insert_coin(2'b01);
            press(2'd1);
            if (err_stock === 1'b1) begin
                pulse_cancel();
                drain(paid);
                break;
            end
            pulse_done();
            vends++;
        end
    endtask

    initial begin
        int paid;
        int n;
        reset = 1;
        coin_valid = 0; coin_value = 0; select_valid = 0; select = 0; cancel = 0;
        restock_we = 0; restock_slot = 0; restock_count = 0; motor_done = 0; hopper_ack = 0;
        repeat (2) @(posedge clk);
        #1 reset = 0;

        check_output("reset_state", state_o, 0);
        check_output("reset_credit", credit, 0);
        check_output("reset_motor_req", motor_req, 0);
        check_output("reset_hopper_req", hopper_req, 0);
        check_output("reset_stock_empty", stock_empty, 0);

        // Exact payment for slot 1
        $display("[TB] exact payment slot 1");
        hopper_seen = 0;
        insert_coin(2'b01);
        check_output("t1_credit", credit, 20);
        check_output("t1_state_credit", state_o, 1);
        press(2'd1);
        check_output("t1_state_vend", state_o, 2);
        check_output("t1_motor_req", motor_req, 1);
        check_output("t1_motor_slot", motor_slot, 1);
        check_output("t1_credit_after_sel", credit, 0);
        pulse_done();
        check_output("t1_motor_off", motor_req, 0);
        check_output("t1_state_idle", state_o, 0);
        tick();
        check_output("t1_no_hopper", hopper_seen, 0);

        // 50c for slot 2, change of 20c
        $display("[TB] change payout slot 2");
        insert_coin(2'b10);
        check_output("t2_credit", credit, 50);
        press(2'd2);
        check_output("t2_credit_vend", credit, 20);
        insert_coin(2'b00);
        check_output("t2_vend_coin_reject", coin_reject, 1);
        check_output("t2_vend_credit_held", credit, 20);
        pulse_done();
        check_output("t2_state_change", state_o, 3);
        check_output("t2_hopper_req", hopper_req, 1);
        hopper_ack = 1;
        tick();
        check_output("t2_credit_10", credit, 10);
        check_output("t2_hopper_still", hopper_req, 1);
        tick();
        hopper_ack = 0;
        check_output("t2_credit_0", credit, 0);
        check_output("t2_hopper_off", hopper_req, 0);
        check_output("t2_state_idle", state_o, 0);

        // Insufficient funds, then cancel
        $display("[TB] insufficient funds and cancel");
        insert_coin(2'b00);
        press(2'd3);
        check_output("t3_err_funds", err_funds, 1);
        check_output("t3_err_stock", err_stock, 0);
        check_output("t3_credit_held", credit, 10);
        check_output("t3_state_held", state_o, 1);
        tick();
        check_output("t3_err_funds_pulse", err_funds, 0);
        pulse_cancel();
        check_output("t3_state_change", state_o, 3);
        drain(paid);
        check_output("t3_paid", paid, 1);
        check_output("t3_state_idle", state_o, 0);

        // Empty slot and credit overflow
        $display("[TB] empty slot and overflow");
        restock_we = 1; restock_slot = 0; restock_count = 0;
        tick();
        restock_we = 0;
        check_output("t4_empty_lag", stock_empty[0], 0);
        tick();
        check_output("t4_empty_set", stock_empty[0], 1);
        insert_coin(2'b11);
        press(2'd0);
        check_output("t4_err_stock", err_stock, 1);
        check_output("t4_err_funds_suppressed", err_funds, 0);
        check_output("t4_credit_held", credit, 100);
        insert_coin(2'b11);
        check_output("t4_credit_200", credit, 200);
        check_output("t4_no_reject", coin_reject, 0);
        insert_coin(2'b11);
        check_output("t4_reject", coin_reject, 1);
        check_output("t4_credit_kept", credit, 200);
        tick();
        check_output("t4_reject_pulse", coin_reject, 0);
        pulse_cancel();
        drain(paid);
        check_output("t4_paid", paid, 20);
        check_output("t4_credit_0", credit, 0);

        // Motor timeout
        $display("[TB] motor timeout");
        insert_coin(2'b01);
        press(2'd1);
        n = 0;
        for (int i = 0; i < MT + 20; i++) begin
            if (state_o != 3'd2) break;
            n++;
            tick();
        end
        check_output("t5_vend_cycles", n, MT);
        check_output("t5_state_fault", state_o, 4);
        check_output("t5_motor_off", motor_req, 0);
        check_output("t5_refund", credit, 20);
        tick();
        check_output("t5_state_change", state_o, 3);
        drain(paid);
        check_output("t5_paid", paid, 2);
        check_output("t5_state_idle", state_o, 0);
        count_slot1(n);
        check_output("t5_slot1_stock", n, 3);
        check_output("t5_slot1_empty", stock_empty[1], 1);

        // Reset during change
        $display("[TB] reset during change");
        insert_coin(2'b01);
        insert_coin(2'b01);
        pulse_cancel();
        tick();
        check_output("t6_state_change", state_o, 3);
        check_output("t6_credit_40", credit, 40);
        check_output("t6_hopper_req", hopper_req, 1);
        #2 reset = 1;
        #1;
        check_output("t6_rst_hopper", hopper_req, 0);
        check_output("t6_rst_credit", credit, 0);
        check_output("t6_rst_state", state_o, 0);
        check_output("t6_rst_stock_empty", stock_empty, 0);
        tick();
        reset = 0;
        count_slot1(n);
        check_output("t6_slot1_stock", n, 4);

        check_output("req_overlap", overlap, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
